// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and stall/flush controller for an in-order pipeline with a
// shadow scoreboard of back-end stages. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_unit #(
    parameter int NUM_STAGES       = 5,
    parameter int NUM_REGS         = 8,
    parameter int WORD_SIZE        = 16,
    parameter int MEM_STAGE        = 3,
    parameter int ALU_READY_STAGE  = 3,
    parameter int LOAD_READY_STAGE = 4
) (
    input  logic                            i_clk,
    input  logic                            i_srst,
    input  logic                            i_dec_valid,
    input  logic                            i_dec_use_x,
    input  logic                            i_dec_use_y,
    input  logic [$clog2(NUM_REGS)-1:0]     i_dec_rx,
    input  logic [$clog2(NUM_REGS)-1:0]     i_dec_ry,
    input  logic                            i_dec_wb,
    input  logic [$clog2(NUM_REGS)-1:0]     i_dec_dst,
    input  logic                            i_dec_is_load,
    input  logic                            i_mem_waitreq,
    input  logic                            i_mem_access,
    input  logic                            i_redirect,
    input  logic [NUM_STAGES*WORD_SIZE-1:0] i_stage_result,
    output logic [NUM_STAGES-1:0]           o_stall,
    output logic [NUM_STAGES-1:0]           o_flush,
    output logic                            o_fwd_x_en,
    output logic                            o_fwd_y_en,
    output logic [WORD_SIZE-1:0]            o_fwd_x_data,
    output logic [WORD_SIZE-1:0]            o_fwd_y_data
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                     o_stall_cycles,
    output logic [31:0]                     o_flush_events,
    output logic [31:0]                     o_freeze_cycles
`endif
);

    localparam int NUM_ENT = NUM_STAGES - 2;
    localparam int REG_W   = $clog2(NUM_REGS);

    // Shadow entry e tracks the instruction in stage e+2.
    logic [NUM_ENT-1:0] r_v;
    logic [NUM_ENT-1:0] r_wb;
    logic [NUM_ENT-1:0] r_ld;
    logic [REG_W-1:0]   r_dst [NUM_ENT];

    logic [NUM_ENT-1:0] w_ready;
    logic [NUM_ENT-1:0] w_match_x;
    logic [NUM_ENT-1:0] w_match_y;

    logic                 w_hit_x, w_hit_y;
    logic                 w_rdy_x, w_rdy_y;
    logic [WORD_SIZE-1:0] w_data_x, w_data_y;
    logic                 w_freeze, w_redirect, w_raw, w_bubble;
    logic                 w_unused_lo;

    generate
        if (NUM_STAGES < 4 || LOAD_READY_STAGE <= MEM_STAGE) begin : g_bad_cfg
            $error("pipeline_hazard_unit: invalid stage configuration");
        end
    endgenerate

    // Fetch/Decode latches never hold a forwardable result.
    assign w_unused_lo = ^i_stage_result[2*WORD_SIZE-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENT; gi++) begin : g_ent
            localparam int STAGE = gi + 2;
            assign w_ready[gi]   = r_ld[gi] ? (STAGE >= LOAD_READY_STAGE)
                                            : (STAGE >= ALU_READY_STAGE);
            assign w_match_x[gi] = i_dec_valid && i_dec_use_x && r_v[gi] && r_wb[gi]
                                   && (r_dst[gi] == i_dec_rx);
            assign w_match_y[gi] = i_dec_valid && i_dec_use_y && r_v[gi] && r_wb[gi]
                                   && (r_dst[gi] == i_dec_ry);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_hit_x  = 1'b0;
        w_rdy_x  = 1'b0;
        w_data_x = '0;
        w_hit_y  = 1'b0;
        w_rdy_y  = 1'b0;
        w_data_y = '0;
        for (int e = NUM_ENT - 1; e >= 0; e--) begin
            if (w_match_x[e]) begin
                w_hit_x  = 1'b1;
                w_rdy_x  = w_ready[e];
                w_data_x = i_stage_result[(e+2)*WORD_SIZE +: WORD_SIZE];
            end
            if (w_match_y[e]) begin
                w_hit_y  = 1'b1;
                w_rdy_y  = w_ready[e];
                w_data_y = i_stage_result[(e+2)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Everything is masked during reset so stale entries or inputs cannot leak out.
    assign w_freeze   = !i_srst && i_mem_waitreq && i_mem_access;
    assign w_redirect = !i_srst && i_redirect;
    assign w_raw      = !i_srst && ((w_hit_x && !w_rdy_x) || (w_hit_y && !w_rdy_y));
    assign w_bubble   = w_redirect || w_raw;

    assign o_fwd_x_en   = !i_srst && w_hit_x && w_rdy_x;
    assign o_fwd_y_en   = !i_srst && w_hit_y && w_rdy_y;
    assign o_fwd_x_data = o_fwd_x_en ? w_data_x : '0;
    assign o_fwd_y_data = o_fwd_y_en ? w_data_y : '0;

    always_comb begin
        o_stall = '0;
        o_flush = '0;
        if (w_freeze) begin
            o_stall = '1;
        end else if (w_redirect) begin
            o_flush[1:0] = 2'b11;
        end else if (w_raw) begin
            o_stall[1:0] = 2'b11;
            o_flush[2]   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_v  <= '0;
            r_wb <= '0;
            r_ld <= '0;
            for (int e = 0; e < NUM_ENT; e++) begin
                r_dst[e] <= '0;
            end
        end else if (!w_freeze) begin
            r_v[0]   <= w_bubble ? 1'b0 : i_dec_valid;
            r_wb[0]  <= w_bubble ? 1'b0 : i_dec_wb;
            r_ld[0]  <= w_bubble ? 1'b0 : i_dec_is_load;
            r_dst[0] <= w_bubble ? '0 : i_dec_dst;
            for (int e = 1; e < NUM_ENT; e++) begin
                r_v[e]   <= r_v[e-1];
                r_wb[e]  <= r_wb[e-1];
                r_ld[e]  <= r_ld[e-1];
                r_dst[e] <= r_dst[e-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles, r_flush_events, r_freeze_cycles;

    // Only count hazard stalls that actually reach the pipeline.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_stall_cycles  <= '0;
            r_flush_events  <= '0;
            r_freeze_cycles <= '0;
        end else begin
            if (w_freeze && r_freeze_cycles != '1)
                r_freeze_cycles <= r_freeze_cycles + 32'd1;
            if (!w_freeze && w_redirect && r_flush_events != '1)
                r_flush_events <= r_flush_events + 32'd1;
            if (!w_freeze && !w_redirect && w_raw && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles  = r_stall_cycles;
    assign o_flush_events  = r_flush_events;
    assign o_freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit at default parameters.
module tb_pipeline_hazard_unit;

    logic        clk = 1'b0;
    logic        srst;
    logic        dec_valid, dec_use_x, dec_use_y, dec_wb, dec_is_load;
    logic [2:0]  dec_rx, dec_ry, dec_dst;
    logic        mem_waitreq, mem_access, redirect;
    logic [79:0] stage_result;
    logic [4:0]  stall, flush;
    logic        fwd_x_en, fwd_y_en;
    logic [15:0] fwd_x_data, fwd_y_data;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, freeze_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    logic [43:0] sb [$];
    logic [43:0] exp_v;
    logic [43:0] w_obs;

    localparam logic [79:0] RES_DEFAULT = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};

    pipeline_hazard_unit dut (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_dec_valid    (dec_valid),
        .i_dec_use_x    (dec_use_x),
        .i_dec_use_y    (dec_use_y),
        .i_dec_rx       (dec_rx),
        .i_dec_ry       (dec_ry),
        .i_dec_wb       (dec_wb),
        .i_dec_dst      (dec_dst),
        .i_dec_is_load  (dec_is_load),
        .i_mem_waitreq  (mem_waitreq),
        .i_mem_access   (mem_access),
        .i_redirect     (redirect),
        .i_stage_result (stage_result),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_fwd_x_en     (fwd_x_en),
        .o_fwd_y_en     (fwd_y_en),
        .o_fwd_x_data   (fwd_x_data),
        .o_fwd_y_data   (fwd_y_data)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_cycles),
        .o_flush_events (flush_events),
        .o_freeze_cycles(freeze_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign w_obs = {stall, flush, fwd_x_en, fwd_x_data, fwd_y_en, fwd_y_data};

    // Drive one cycle of inputs and queue the outputs expected for that cycle.
    task automatic drive(input logic rst, v, ux, input logic [2:0] rx, input logic uy,
                         input logic [2:0] ry, input logic wb, input logic [2:0] dst,
                         input logic ld, wq, acc, rd, input logic [4:0] es, ef,
                         input logic xe, input logic [15:0] xd, input logic ye,
                         input logic [15:0] yd);
        srst = rst; dec_valid = v; dec_use_x = ux; dec_rx = rx; dec_use_y = uy;
        dec_ry = ry; dec_wb = wb; dec_dst = dst; dec_is_load = ld;
        mem_waitreq = wq; mem_access = acc; redirect = rd;
        sb.push_back({es, ef, xe, xd, ye, yd});
    endtask

    task automatic idle();
        drive(0, 0,0,0,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            case (s)
                0: drive(1, 0,0,0,0,0, 0,0,0, 1,1,1, 5'b0,5'b0, 0,16'h0,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL reset step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_dep();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,3,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1: drive(0, 1,1,3,0,0, 1,5,0, 0,0,0, 5'b00011,5'b00100, 0,16'h0,0,16'h0);
                2: drive(0, 1,1,3,0,0, 1,5,0, 0,0,0, 5'b0,5'b0, 1,16'h3333,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL alu_dep step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,2,1, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1, 2: drive(0, 1,0,0,1,2, 0,0,0, 0,0,0, 5'b00011,5'b00100, 0,16'h0,0,16'h0);
                3: drive(0, 1,0,0,1,2, 0,0,0, 0,0,0, 5'b0,5'b0, 0,16'h0,1,16'h4444);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL load_use step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_distance();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,4,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1: drive(0, 1,0,0,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                2: drive(0, 1,1,4,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h3333,0,16'h0);
                3: drive(0, 1,0,0,1,4, 0,0,0, 0,0,0, 5'b0,5'b0, 0,16'h0,1,16'h4444);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL distance step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        stage_result = {16'h00BB, 16'h00AA, 16'h2222, 16'h1111, 16'h0000};
        for (int s = 0; s < 15; s++) begin
            case (s)
                0, 1, 7: drive(0, 1,0,0,0,0, 1,1,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                3: drive(0, 1,1,1,1,1, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h00AA,1,16'h00AA);
                4: drive(0, 1,1,1,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h00BB,0,16'h0);
                9: drive(0, 1,0,0,0,0, 1,1,1, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                10, 11: drive(0, 1,1,1,0,0, 0,0,0, 0,0,0, 5'b00011,5'b00100, 0,16'h0,0,16'h0);
                12: drive(0, 1,1,1,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h00BB,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL youngest step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
        stage_result = RES_DEFAULT;
    endtask

    task automatic test_freeze();
        for (int s = 0; s < 8; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,3,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1, 2, 3: drive(0, 1,1,3,0,0, 0,0,0, 1,1,0, 5'b11111,5'b0, 0,16'h0,0,16'h0);
                4: drive(0, 1,1,3,0,0, 0,0,0, 1,0,0, 5'b00011,5'b00100, 0,16'h0,0,16'h0);
                5: drive(0, 1,1,3,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h3333,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL freeze step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,3,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1: drive(0, 1,1,3,0,0, 1,3,0, 0,0,1, 5'b0,5'b00011, 0,16'h0,0,16'h0);
                2: drive(0, 1,1,3,0,0, 0,0,0, 0,0,0, 5'b0,5'b0, 1,16'h3333,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL redirect step %0d: got %h expected %h", s, w_obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: drive(0, 1,0,0,0,0, 1,5,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                1: drive(1, 1,1,5,1,5, 0,0,0, 1,1,1, 5'b0,5'b0, 0,16'h0,0,16'h0);
                2: drive(0, 1,1,5,1,5, 0,0,0, 0,0,0, 5'b0,5'b0, 0,16'h0,0,16'h0);
                default: idle();
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            checks++;
            if (w_obs !== exp_v) begin
                failures++;
                $display("FAIL reset_mid step %0d: got %h expected %h", s, w_obs, exp_v);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (s == 2) begin
                checks++;
                if ({stall_cycles, flush_events, freeze_cycles} !== 96'h0) begin
                    failures++;
                    $display("FAIL reset_mid counters: got %h %h %h expected 0 0 0",
                             stall_cycles, flush_events, freeze_cycles);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        stage_result = RES_DEFAULT;
        test_reset();
        test_alu_dep();
        test_load_use();
        test_distance();
        test_youngest();
        test_freeze();
        test_redirect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
